// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package rv32_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rv32_imm_packer.sv
// Combinational packing of instruction fields into an RV32I word.
// Immediate range checking is present only when RV32_ENC_IMM_CHECK_EN is defined.
module rv32_imm_packer
    import rv32_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        fmt_illegal,
    output logic        imm_bad
);

    always_comb begin
        word        = NOP_WORD;
        fmt_illegal = 1'b0;
        case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: fmt_illegal = 1'b1;
        endcase
    end

`ifdef RV32_ENC_IMM_CHECK_EN
    logic i_bad;
    logic b_bad;
    logic j_bad;
    logic u_bad;

    // A value fits a signed N-bit field when all bits above N-2 equal the sign.
    assign i_bad = ~((&imm[31:11]) | ~(|imm[31:11]));
    assign b_bad = ~((&imm[31:12]) | ~(|imm[31:12])) | imm[0];
    assign j_bad = ~((&imm[31:20]) | ~(|imm[31:20])) | imm[0];
    assign u_bad = |imm[11:0];

    always_comb begin
        imm_bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: imm_bad = i_bad;
            FMT_B:        imm_bad = b_bad;
            FMT_J:        imm_bad = j_bad;
            FMT_U:        imm_bad = u_bad;
            default:      imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
`endif

endmodule

// File: rtl/rv32_instr_encoder.sv
// Streams instruction field bundles into packed RV32I words written to imem.
// Optional immediate range checking: define RV32_ENC_IMM_CHECK_EN.
module rv32_instr_encoder
    import rv32_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        wr_en,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        done,
    output logic        err_fmt,
    output logic        err_ovf,
    output logic        imm_err
);

    localparam int IW = $clog2(DEPTH) + 1;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          wr_en_q, wr_en_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          last_q, last_d;
    logic          err_fmt_q, err_fmt_d;
    logic          err_ovf_q, err_ovf_d;
    logic          imm_err_q, imm_err_d;

    logic [31:0]   pk_word;
    logic          pk_fmt_illegal;
    logic          pk_imm_bad;
    logic          accept;
    logic          drain;
    logic [IW-1:0] slot;
    logic          slot_full;

    rv32_imm_packer u_packer (
        .fmt         (in_fmt),
        .opcode      (in_opcode),
        .rd          (in_rd),
        .rs1         (in_rs1),
        .rs2         (in_rs2),
        .funct3      (in_funct3),
        .funct7      (in_funct7),
        .imm         (in_imm),
        .word        (pk_word),
        .fmt_illegal (pk_fmt_illegal),
        .imm_bad     (pk_imm_bad)
    );

    // Once the last bundle is taken, nothing more belongs to this burst.
    assign in_ready = (state_q == ST_RUN) & ~err_ovf_q & ~last_q & (~wr_en_q | wr_ready);
    assign accept   = in_valid & in_ready;
    assign drain    = wr_en_q & wr_ready;

    // An accepted bundle lands in the slot after any word draining this cycle.
    assign slot      = idx_q + {{(IW-1){1'b0}}, wr_en_q};
    assign slot_full = (slot == IW'(DEPTH));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
        last_d    = last_q;
        err_fmt_d = err_fmt_q;
        err_ovf_d = err_ovf_q;
        imm_err_d = imm_err_q;

        if (drain) begin
            wr_en_d = 1'b0;
            idx_d   = idx_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    idx_d     = '0;
                    last_d    = 1'b0;
                    err_fmt_d = 1'b0;
                    err_ovf_d = 1'b0;
                    imm_err_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (slot_full) begin
                        err_ovf_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = pk_word;
                        last_d    = in_last;
                        err_fmt_d = err_fmt_q | pk_fmt_illegal;
                        imm_err_d = imm_err_q | pk_imm_bad;
                    end
                end
                if (drain && last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            last_q    <= 1'b0;
            err_fmt_q <= 1'b0;
            err_ovf_q <= 1'b0;
            imm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            last_q    <= last_d;
            err_fmt_q <= err_fmt_d;
            err_ovf_q <= err_ovf_d;
            imm_err_q <= imm_err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign wr_addr = BASE_ADDR + {{(30-IW){1'b0}}, idx_q, 2'b00};
    assign done    = (state_q == ST_DONE);
    assign err_fmt = err_fmt_q;
    assign err_ovf = err_ovf_q;
    assign imm_err = imm_err_q;

endmodule
